// File: rtl/systolic_feeder_2x2.sv
// systolic_feeder_2x2
//
// Control and operand-sequencing front end for a 2x2 output-stationary
// systolic matrix-multiply array. One (A, B) job is accepted per handshake.
// The feeder clears the array accumulators and streams skewed operands into
// the array. It then runs the array with zero operands until the last
// products have landed, captures C = A x B, and holds C on a valid/ready
// result port.
//
// Ports
//   clk                  rising-edge clock
//   rst                  asynchronous active-low reset (0 = reset)
//   in_valid / in_ready  job handshake; in_ready is high only in IDLE
//   a_mat, b_mat         operands packed {X11,X10,X01,X00}, X00 in LSBs
//   arr_clr              accumulator clear to the array (never with arr_valid)
//   arr_valid            valid_in to the array
//   arr_a0/a1, arr_b0/b1 skewed operands to a_data0/1 and b_data0/1
//   arr_c00..arr_c11     accumulator outputs from the array
//   res_valid/res_ready  result handshake
//   res_mat              result packed {C11,C10,C01,C00}, held while res_valid
//   busy                 high whenever the feeder is not IDLE
//
// Every output is registered. The combinational process computes each
// output's value for the next cycle from the next state.

module systolic_feeder_2x2 #(
    parameter int WIDTH        = 8,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*WIDTH-1:0]   a_mat,
    input  logic [4*WIDTH-1:0]   b_mat,
    output logic                 arr_clr,
    output logic                 arr_valid,
    output logic [WIDTH-1:0]     arr_a0,
    output logic [WIDTH-1:0]     arr_a1,
    output logic [WIDTH-1:0]     arr_b0,
    output logic [WIDTH-1:0]     arr_b1,
    input  logic [2*WIDTH-1:0]   arr_c00,
    input  logic [2*WIDTH-1:0]   arr_c01,
    input  logic [2*WIDTH-1:0]   arr_c10,
    input  logic [2*WIDTH-1:0]   arr_c11,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [8*WIDTH-1:0]   res_mat,
    output logic                 busy
);

    // One counter serves both the 3 feed steps and the drain cycles.
    localparam int CNT_MAX = (DRAIN_CYCLES > 3) ? DRAIN_CYCLES : 3;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               load;

    logic [4*WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0]   a00, a01, a10, a11, b00, b01, b10, b11;

    logic               in_ready_nxt, arr_clr_nxt, arr_valid_nxt;
    logic               res_valid_nxt, busy_nxt;
    logic [WIDTH-1:0]   arr_a0_nxt, arr_a1_nxt, arr_b0_nxt, arr_b1_nxt;
    logic [8*WIDTH-1:0] res_mat_nxt;

    assign a00 = a_q[WIDTH-1:0];
    assign a01 = a_q[2*WIDTH-1:WIDTH];
    assign a10 = a_q[3*WIDTH-1:2*WIDTH];
    assign a11 = a_q[4*WIDTH-1:3*WIDTH];
    assign b00 = b_q[WIDTH-1:0];
    assign b01 = b_q[2*WIDTH-1:WIDTH];
    assign b10 = b_q[3*WIDTH-1:2*WIDTH];
    assign b11 = b_q[4*WIDTH-1:3*WIDTH];

    // Operand capture is pure data: it needs no reset because it is only
    // read after a job has been accepted.
    always_ff @(posedge clk) begin
        if (load) begin
            a_q <= a_mat;
            b_q <= b_mat;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        load          = 1'b0;
        arr_clr_nxt   = 1'b0;
        arr_valid_nxt = 1'b0;
        arr_a0_nxt    = '0;
        arr_a1_nxt    = '0;
        arr_b0_nxt    = '0;
        arr_b1_nxt    = '0;
        res_valid_nxt = res_valid;
        res_mat_nxt   = res_mat;

        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    load        = 1'b1;
                    state_nxt   = S_CLEAR;
                    arr_clr_nxt = 1'b1;
                end
            end
            S_CLEAR: begin
                // Present the t=0 feed step on the next cycle.
                state_nxt     = S_FEED;
                cnt_nxt       = '0;
                arr_valid_nxt = 1'b1;
                arr_a0_nxt    = a00;
                arr_b0_nxt    = b00;
            end
            S_FEED: begin
                // cnt is the step currently on the outputs; compute the next one.
                arr_valid_nxt = 1'b1;
                if (cnt == CNT_W'(0)) begin
                    cnt_nxt    = CNT_W'(1);
                    arr_a0_nxt = a01;
                    arr_a1_nxt = a10;
                    arr_b0_nxt = b10;
                    arr_b1_nxt = b01;
                end else if (cnt == CNT_W'(1)) begin
                    cnt_nxt    = CNT_W'(2);
                    arr_a1_nxt = a11;
                    arr_b1_nxt = b11;
                end else begin
                    state_nxt = S_DRAIN;
                    cnt_nxt   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt == CNT_W'(DRAIN_CYCLES - 1)) begin
                    state_nxt     = S_DONE;
                    res_valid_nxt = 1'b1;
                    res_mat_nxt   = {arr_c11, arr_c10, arr_c01, arr_c00};
                end else begin
                    cnt_nxt       = cnt + CNT_W'(1);
                    arr_valid_nxt = 1'b1;
                end
            end
            S_DONE: begin
                if (res_valid && res_ready) begin
                    state_nxt     = S_IDLE;
                    res_valid_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        in_ready_nxt = (state_nxt == S_IDLE);
        busy_nxt     = (state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            arr_clr   <= 1'b0;
            arr_valid <= 1'b0;
            arr_a0    <= '0;
            arr_a1    <= '0;
            arr_b0    <= '0;
            arr_b1    <= '0;
            res_valid <= 1'b0;
            res_mat   <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            in_ready  <= in_ready_nxt;
            arr_clr   <= arr_clr_nxt;
            arr_valid <= arr_valid_nxt;
            arr_a0    <= arr_a0_nxt;
            arr_a1    <= arr_a1_nxt;
            arr_b0    <= arr_b0_nxt;
            arr_b1    <= arr_b1_nxt;
            res_valid <= res_valid_nxt;
            res_mat   <= res_mat_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule
